pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit_if.sv | 38 +++
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Redirect, instruction-memory request/response and decode-side
//               instruction handshake signals of the fetch unit.
//               master = fetch unit, slave = surrounding memory/decode logic.
// Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_add_4;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data,
               inst_pc, inst_pc_add_4
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data,
               inst_pc, inst_pc_add_4
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pc_fetch_unit
// Description : Holds the fetch PC, issues one instruction-memory read at a
//               time and queues returned words with their PC in a 2-entry
//               buffer toward decode. Redirects flush the stream.
// Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          BUF_DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_outstanding;
    logic        r_stale;

    logic [1:0]  r_count;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_data [2];

    logic        w_credit_ok;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_redirect_pc;

    // Misaligned targets are accepted; the low two bits are simply dropped.
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    // Credit uses the registered occupancy only, so a pop this cycle does not
    // free a slot for a request in the same cycle.
    assign w_credit_ok = (int'(r_count) + int'(r_outstanding)) < BUF_DEPTH;
    assign w_req_valid = reset && !bus.redirect && (r_state == S_REQ) && w_credit_ok;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;

    assign w_pop  = (r_count != 2'd0) && bus.inst_ready;
    assign w_push = (r_state == S_WAIT) && bus.imem_rsp_valid && !r_stale && !bus.redirect;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = (r_count != 2'd0);
    assign bus.inst_data      = r_buf_data[0];
    assign bus.inst_pc        = r_buf_pc[0];
    assign bus.inst_pc_add_4  = r_buf_pc[0] + 32'd4;

    // Fetch sequencing: PC advance, request/response tracking, stale marking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_REQ;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= 32'd0;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
        end else if (bus.redirect) begin
            r_fetch_pc <= w_redirect_pc;
            if (r_state == S_WAIT) begin
                if (bus.imem_rsp_valid) begin
                    // The in-flight word lands now and is thrown away.
                    r_state       <= S_REQ;
                    r_outstanding <= 1'b0;
                    r_stale       <= 1'b0;
                end else begin
                    // Still waiting: the eventual word belongs to the old stream.
                    r_stale <= 1'b1;
                end
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_req_pc      <= r_fetch_pc;
                        r_fetch_pc    <= r_fetch_pc + 32'd4;
                        r_outstanding <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_stale       <= 1'b0;
                        r_outstanding <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Two-entry instruction buffer; entry 0 is always the head.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]   <= 32'd0;
                r_buf_data[i] <= 32'd0;
            end
        end else if (bus.redirect) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_buf_pc[r_count[0]]   <= r_req_pc;
                    r_buf_data[r_count[0]] <= bus.imem_rsp_data;
                    r_count                <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf_pc[0]   <= r_buf_pc[1];
                    r_buf_data[0] <= r_buf_data[1];
                    r_count       <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf_pc[0]   <= r_req_pc;
                        r_buf_data[0] <= bus.imem_rsp_data;
                    end else begin
                        r_buf_pc[0]   <= r_buf_pc[1];
                        r_buf_data[0] <= r_buf_data[1];
                        r_buf_pc[1]   <= r_req_pc;
                        r_buf_data[1] <= bus.imem_rsp_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit: queue-based reference
//               model compared every cycle, memory responder with
//               programmable latency, and directed scenarios with literal
//               expectations on the decoded PC stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pc_fetch_unit_if bus_if ();

    pc_fetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // ---------------- memory responder ----------------
    int          rsp_lat = 0;
    logic        rsp_pend = 1'b0;
    logic [31:0] rsp_addr = 32'd0;
    int          rsp_cnt = 0;
    logic        tb_hs;
    logic [31:0] tb_ha;

    initial begin
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = 32'd0;
        forever begin
            @(posedge clk);
            tb_hs = bus_if.imem_req_valid && bus_if.imem_req_ready;
            tb_ha = bus_if.imem_req_addr;
            #1;
            bus_if.imem_rsp_valid = 1'b0;
            if (tb_hs) begin
                rsp_pend = 1'b1;
                rsp_addr = tb_ha;
                rsp_cnt  = rsp_lat;
            end
            if (rsp_pend) begin
                if (rsp_cnt == 0) begin
                    bus_if.imem_rsp_valid = 1'b1;
                    bus_if.imem_rsp_data  = mem_word(rsp_addr);
                    rsp_pend = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [63:0] m_q[$];
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_reqpc = 32'd0;
    bit          m_wait  = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_init  = 1'b0;
    bit          m_hs;

    function automatic bit m_req_valid();
        return reset && !bus_if.redirect && !m_wait && (m_q.size() < 2);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_pc    = c_RESET_PC;
                m_q.delete();
                m_wait  = 1'b0;
                m_stale = 1'b0;
                m_init  = 1'b1;
            end else if (m_init) begin
                m_hs = m_req_valid() && bus_if.imem_req_ready;
                if (m_q.size() != 0 && bus_if.inst_ready)
                    void'(m_q.pop_front());
                if (bus_if.redirect) begin
                    m_q.delete();
                    m_pc = {bus_if.redirect_pc[31:2], 2'b00};
                    if (m_wait) begin
                        if (bus_if.imem_rsp_valid) begin
                            m_wait  = 1'b0;
                            m_stale = 1'b0;
                        end else begin
                            m_stale = 1'b1;
                        end
                    end
                end else if (m_hs) begin
                    m_reqpc = m_pc;
                    m_pc    = m_pc + 32'd4;
                    m_wait  = 1'b1;
                end else if (m_wait && bus_if.imem_rsp_valid) begin
                    if (!m_stale)
                        m_q.push_back({m_reqpc, bus_if.imem_rsp_data});
                    m_stale = 1'b0;
                    m_wait  = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_init) begin
            chk("req_valid", {31'd0, bus_if.imem_req_valid}, {31'd0, m_req_valid()});
            chk("req_addr", bus_if.imem_req_addr, m_pc);
            chk("inst_valid", {31'd0, bus_if.inst_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("inst_pc", bus_if.inst_pc, m_q[0][63:32]);
                chk("inst_data", bus_if.inst_data, m_q[0][31:0]);
                chk("inst_pc_add_4", bus_if.inst_pc_add_4, m_q[0][63:32] + 32'd4);
            end
        end
    end

    // PCs actually consumed by decode, checked against literal lists.
    logic [31:0] pop_log[$];
    always @(negedge clk) begin
        if (reset && bus_if.inst_valid && bus_if.inst_ready)
            pop_log.push_back(bus_if.inst_pc);
    end

    task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] act;
        act = (idx < pop_log.size()) ? pop_log[idx] : 32'hxxxx_xxxx;
        chk(name, act, exp);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset                 = 1'b0;
        bus_if.redirect       = 1'b0;
        bus_if.imem_req_ready = 1'b0;
        bus_if.inst_ready     = 1'b0;
        tick(8);
        pop_log.delete();
    endtask

    task automatic wait_rsp(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 40 && seen < n; i++) begin
            tick();
            if (bus_if.imem_rsp_valid) seen++;
        end
        chk(name, seen, n);
    endtask

    task automatic wait_issue(input logic [31:0] target, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (bus_if.imem_req_valid && bus_if.imem_req_addr == target) found = 1'b1;
            else tick();
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bus_if.redirect       = 1'b0;
        bus_if.redirect_pc    = 32'd0;
        bus_if.imem_req_ready = 1'b0;
        bus_if.inst_ready     = 1'b0;
        tick(2);

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", {31'd0, bus_if.imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        chk("rst_inst_data", bus_if.inst_data, 32'd0);
        chk("rst_inst_pc", bus_if.inst_pc, 32'd0);
        chk("rst_addr", bus_if.imem_req_addr, 32'h0000_3000);

        // 1: sequential stream, 0-wait memory
        tick();
        rsp_lat = 0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.inst_ready     = 1'b1;
        reset = 1'b1;
        tick(12);
        chk_pop("t1_pop0", 0, 32'h0000_3000);
        chk_pop("t1_pop1", 1, 32'h0000_3004);
        chk_pop("t1_pop2", 2, 32'h0000_3008);

        // 2: decode stalled, buffer fills at two
        do_reset();
        bus_if.imem_req_ready = 1'b1;
        reset = 1'b1;
        tick(10);
        @(negedge clk);
        chk("t2_req_blocked", {31'd0, bus_if.imem_req_valid}, 32'd0);
        chk("t2_head_pc", bus_if.inst_pc, 32'h0000_3000);
        chk("t2_head_data", bus_if.inst_data, mem_word(32'h0000_3000));
        tick();
        bus_if.inst_ready = 1'b1;
        @(negedge clk);
        chk("t2_no_pop_credit", {31'd0, bus_if.imem_req_valid}, 32'd0);
        tick();
        bus_if.inst_ready = 1'b0;
        @(negedge clk);
        chk("t2_req_after_pop", {31'd0, bus_if.imem_req_valid}, 32'd1);
        chk("t2_addr_after_pop", bus_if.imem_req_addr, 32'h0000_3008);
        chk("t2_head_after_pop", bus_if.inst_pc, 32'h0000_3004);

        // 3: redirect while 3004 outstanding, late stale response
        do_reset();
        rsp_lat = 3;
        bus_if.imem_req_ready = 1'b1;
        bus_if.inst_ready     = 1'b1;
        reset = 1'b1;
        wait_issue(32'h0000_3004, "t3_issue_3004");
        tick();
        rsp_lat = 0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h0000_3100;
        @(negedge clk);
        chk("t3_no_req_on_redirect", {31'd0, bus_if.imem_req_valid}, 32'd0);
        tick();
        bus_if.redirect = 1'b0;
        @(negedge clk);
        chk("t3_flushed", {31'd0, bus_if.inst_valid}, 32'd0);
        chk("t3_addr", bus_if.imem_req_addr, 32'h0000_3100);
        chk("t3_wait_stale", {31'd0, bus_if.imem_req_valid}, 32'd0);
        tick(14);
        chk_pop("t3_pop0", 0, 32'h0000_3000);
        chk_pop("t3_pop1", 1, 32'h0000_3100);
        chk_pop("t3_pop2", 2, 32'h0000_3104);

        // 4: misaligned target, back-to-back redirects, address wrap
        do_reset();
        reset = 1'b1;
        tick();
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h0000_3103;
        @(negedge clk);
        chk("t4_no_req_on_redirect", {31'd0, bus_if.imem_req_valid}, 32'd0);
        tick();
        bus_if.redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("t4_addr_aligned", bus_if.imem_req_addr, 32'h0000_3100);
        tick();
        bus_if.redirect = 1'b0;
        @(negedge clk);
        chk("t4_addr_last_wins", bus_if.imem_req_addr, 32'hFFFF_FFFC);
        chk("t4_req_valid", {31'd0, bus_if.imem_req_valid}, 32'd1);
        tick();
        rsp_lat = 0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.inst_ready     = 1'b1;
        tick(10);
        chk_pop("t4_pop0", 0, 32'hFFFF_FFFC);
        chk_pop("t4_pop1", 1, 32'h0000_0000);
        chk_pop("t4_pop2", 2, 32'h0000_0004);

        // 5: ready held low, then reset during WAIT with a late response
        do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_hold_addr%0d", i), bus_if.imem_req_addr, 32'h0000_3000);
            chk($sformatf("t5_hold_valid%0d", i), {31'd0, bus_if.imem_req_valid}, 32'd1);
            tick();
        end
        rsp_lat = 5;
        bus_if.imem_req_ready = 1'b1;
        tick();
        bus_if.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("t5_in_wait", {31'd0, bus_if.imem_req_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_addr_after_reset", bus_if.imem_req_addr, 32'h0000_3000);
        chk("t5_valid_after_reset", {31'd0, bus_if.imem_req_valid}, 32'd1);
        tick(6);
        @(negedge clk);
        chk("t5_late_rsp_ignored", {31'd0, bus_if.inst_valid}, 32'd0);
        tick();
        rsp_lat = 0;
        bus_if.imem_req_ready = 1'b1;
        bus_if.inst_ready     = 1'b1;
        tick(8);
        chk_pop("t5_pop0", 0, 32'h0000_3000);
        chk_pop("t5_pop1", 1, 32'h0000_3004);

        // 6: redirect coincides with a response while a word is buffered
        do_reset();
        rsp_lat = 2;
        bus_if.imem_req_ready = 1'b1;
        reset = 1'b1;
        wait_rsp(2, "t6_second_rsp");
        rsp_lat = 0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h0000_4000;
        bus_if.inst_ready  = 1'b1;
        @(negedge clk);
        chk("t6_pop_visible", {31'd0, bus_if.inst_valid}, 32'd1);
        chk("t6_pop_pc", bus_if.inst_pc, 32'h0000_3000);
        tick();
        bus_if.redirect = 1'b0;
        @(negedge clk);
        chk("t6_empty_after", {31'd0, bus_if.inst_valid}, 32'd0);
        tick(10);
        chk_pop("t6_pop0", 0, 32'h0000_3000);
        chk_pop("t6_pop1", 1, 32'h0000_4000);
        chk_pop("t6_pop2", 2, 32'h0000_4004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
